// File: rtl/l1_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l1_bus_arbiter_pkg
//   Shared definitions for the L1 shared-bus arbiter: bus message encodings,
//   arbiter FSM state type and the helper that sizes the offset fields.
// ---------------------------------------------------------------------------
package l1_bus_arbiter_pkg;

  // Bus message encodings understood by every L1 wrapper, snooper and memory.
  typedef enum logic [3:0] {
    NO_REQ    = 4'd0,
    R_REQ     = 4'd1,
    WB_REQ    = 4'd2,
    FLUSH     = 4'd3,
    INVLD     = 4'd4,
    RFO_BCAST = 4'd5,
    MEM_RESP  = 4'd6,
    C_RESP    = 4'd7,
    HOLD_BUS  = 4'd8
  } bus_msg_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  // Width of an active_offset field for a given largest cache offset.
  function automatic int ofs_width(input int max_offset_bits);
    return $clog2(max_offset_bits) + 1;
  endfunction

endpackage

// File: rtl/l1_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// l1_bus_arbiter_if
//   Bundle of the L1-side request buses, memory-side response inputs and the
//   shared snoop-bus outputs.
//   slave  : arbiter view (consumes cache/memory inputs, drives the bus).
//   master : environment view (drives requests/responses, observes the bus).
//   Handshake: a cache requests by holding a non-NO_REQ message until it sees
//   its bit in bus_master; req_ready marks an active tenure, and the master
//   ends it by returning its message to NO_REQ.
// ---------------------------------------------------------------------------
interface l1_bus_arbiter_if #(
  parameter int NUM_CACHES      = 4,
  parameter int MSG_BITS        = 4,
  parameter int ADDRESS_BITS    = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BUS_OFFSET_BITS = 0,
  parameter int MAX_OFFSET_BITS = 3
);
  import l1_bus_arbiter_pkg::*;

  localparam int BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS;
  localparam int OFS_W     = ofs_width(MAX_OFFSET_BITS);

  logic [NUM_CACHES*MSG_BITS-1:0]     cache_msg_in;
  logic [NUM_CACHES*ADDRESS_BITS-1:0] cache_address_in;
  logic [NUM_CACHES*BUS_WIDTH-1:0]    cache_data_in;
  logic [NUM_CACHES*OFS_W-1:0]        cache_active_offset;
  logic [MSG_BITS-1:0]                mem_msg_in;
  logic [ADDRESS_BITS-1:0]            mem_address_in;
  logic [BUS_WIDTH-1:0]               mem_data_in;
  logic [MSG_BITS-1:0]                bus_msg_out;
  logic [ADDRESS_BITS-1:0]            bus_address_out;
  logic [BUS_WIDTH-1:0]               bus_data_out;
  logic [NUM_CACHES-1:0]              bus_master;
  logic                               req_ready;
  logic [OFS_W-1:0]                   curr_offset;
  logic                               timeout_err;

  modport slave (
    input  cache_msg_in, cache_address_in, cache_data_in, cache_active_offset,
    input  mem_msg_in, mem_address_in, mem_data_in,
    output bus_msg_out, bus_address_out, bus_data_out,
    output bus_master, req_ready, curr_offset, timeout_err
  );

  modport master (
    output cache_msg_in, cache_address_in, cache_data_in, cache_active_offset,
    output mem_msg_in, mem_address_in, mem_data_in,
    input  bus_msg_out, bus_address_out, bus_data_out,
    input  bus_master, req_ready, curr_offset, timeout_err
  );

endinterface

// File: rtl/l1_bus_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l1_bus_arbiter_rr_arbiter
//   Combinational round-robin pick: first set bit of req_i scanning from
//   ptr_i upward, wrapping modulo NUM_REQ.
//   req_i   : request vector          ptr_i   : scan start index
//   grant_o : one-hot winner          valid_o : any request present
//   idx_o   : binary index of winner
// ---------------------------------------------------------------------------
module l1_bus_arbiter_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    logic [31:0] pos;
    grant_o = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr_i) + 32'(k)) % 32'(NUM_REQ);
      if (!valid_o && req_i[pos[IDX_W-1:0]]) begin
        valid_o                   = 1'b1;
        grant_o[pos[IDX_W-1:0]]   = 1'b1;
        idx_o                     = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/l1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// l1_bus_arbiter
//   Round-robin shared-bus arbiter for the L1 cache wrappers. Grants one
//   cache a tenure at a time, broadcasts its request on the shared bus and
//   merges memory-side responses onto the same bus (responses win).
//   clock, reset (async, active-low)
//   bus_if    : slave modport carrying cache/memory inputs and bus outputs
//   dbg_state : current arbiter FSM state
// ---------------------------------------------------------------------------
module l1_bus_arbiter
  import l1_bus_arbiter_pkg::*;
#(
  parameter int NUM_CACHES      = 4,
  parameter int MSG_BITS        = 4,
  parameter int ADDRESS_BITS    = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BUS_OFFSET_BITS = 0,
  parameter int MAX_OFFSET_BITS = 3,
  parameter int TIMEOUT         = 1024
) (
  input  logic            clock,
  input  logic            reset,
  l1_bus_arbiter_if.slave bus_if,
  output arb_state_e      dbg_state
);

  localparam int BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS;
  localparam int OFS_W     = ofs_width(MAX_OFFSET_BITS);
  localparam int IDX_W     = $clog2(NUM_CACHES);
  localparam int CNT_W     = $clog2(TIMEOUT) + 1;
  localparam logic [MSG_BITS-1:0] NO_REQ_MSG = MSG_BITS'(NO_REQ);

  logic [MSG_BITS-1:0]     msg_arr  [NUM_CACHES];
  logic [ADDRESS_BITS-1:0] addr_arr [NUM_CACHES];
  logic [BUS_WIDTH-1:0]    data_arr [NUM_CACHES];
  logic [OFS_W-1:0]        ofs_arr  [NUM_CACHES];
  logic [NUM_CACHES-1:0]   req_vec;

  for (genvar i = 0; i < NUM_CACHES; i++) begin : g_unpack
    assign msg_arr[i]  = bus_if.cache_msg_in[i*MSG_BITS +: MSG_BITS];
    assign addr_arr[i] = bus_if.cache_address_in[i*ADDRESS_BITS +: ADDRESS_BITS];
    assign data_arr[i] = bus_if.cache_data_in[i*BUS_WIDTH +: BUS_WIDTH];
    assign ofs_arr[i]  = bus_if.cache_active_offset[i*OFS_W +: OFS_W];
    assign req_vec[i]  = (msg_arr[i] != NO_REQ_MSG);
  end

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      master_idx_q, master_idx_d;
  logic [NUM_CACHES-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]      tenure_cnt_q, tenure_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [NUM_CACHES-1:0] arb_grant;
  logic                  arb_valid;
  logic [IDX_W-1:0]      arb_idx;

  l1_bus_arbiter_rr_arbiter #(.NUM_REQ(NUM_CACHES)) u_rr_arbiter (
    .req_i   (req_vec),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  logic master_release;
  logic tenure_expired;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    master_idx_d   = master_idx_q;
    grant_d        = grant_q;
    tenure_cnt_d   = tenure_cnt_q;
    timeout_err_d  = timeout_err_q;
    master_release = (msg_arr[master_idx_q] == NO_REQ_MSG);
    tenure_expired = (tenure_cnt_q == CNT_W'(TIMEOUT - 1));
    case (state_q)
      ST_IDLE: begin
        // The winner is registered even if it drops its request this cycle;
        // its tenure then ends through the normal release path.
        if (arb_valid) begin
          state_d      = ST_GRANTED;
          grant_d      = arb_grant;
          master_idx_d = arb_idx;
          tenure_cnt_d = '0;
        end
      end
      ST_GRANTED: begin
        tenure_cnt_d = tenure_cnt_q + CNT_W'(1);
        if (master_release || tenure_expired) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          tenure_cnt_d = '0;
          rr_ptr_d     = (master_idx_q == IDX_W'(NUM_CACHES - 1)) ?
                         '0 : master_idx_q + IDX_W'(1);
          if (!master_release) timeout_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      master_idx_q  <= '0;
      grant_q       <= '0;
      tenure_cnt_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      master_idx_q  <= master_idx_d;
      grant_q       <= grant_d;
      tenure_cnt_q  <= tenure_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Bus mux: memory responses pre-empt the master; reset forces an idle bus
  // even while the memory side is still driving.
  logic [MSG_BITS-1:0]     bus_msg;
  logic [ADDRESS_BITS-1:0] bus_addr;
  logic [BUS_WIDTH-1:0]    bus_data;
  logic [OFS_W-1:0]        curr_ofs;

  always_comb begin
    bus_msg  = NO_REQ_MSG;
    bus_addr = '0;
    bus_data = '0;
    curr_ofs = '0;
    if (!reset) begin
      bus_msg  = NO_REQ_MSG;
    end else if (bus_if.mem_msg_in != NO_REQ_MSG) begin
      bus_msg  = bus_if.mem_msg_in;
      bus_addr = bus_if.mem_address_in;
      bus_data = bus_if.mem_data_in;
    end else if (state_q == ST_GRANTED) begin
      bus_msg  = msg_arr[master_idx_q];
      bus_addr = addr_arr[master_idx_q];
      bus_data = data_arr[master_idx_q];
    end
    if (state_q == ST_GRANTED) curr_ofs = ofs_arr[master_idx_q];
  end

  assign bus_if.bus_msg_out     = bus_msg;
  assign bus_if.bus_address_out = bus_addr;
  assign bus_if.bus_data_out    = bus_data;
  assign bus_if.curr_offset     = curr_ofs;
  assign bus_if.bus_master      = grant_q;
  assign bus_if.req_ready       = (state_q == ST_GRANTED);
  assign bus_if.timeout_err     = timeout_err_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1_bus_arbiter
//   Directed bench for l1_bus_arbiter (4 caches, TIMEOUT=16). The driver sets
//   inputs just after each rising edge and queues the observation expected
//   for that cycle; the monitor compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_l1_bus_arbiter;
  import l1_bus_arbiter_pkg::*;

  localparam int W = 4 + 1 + 4 + 32 + 32 + 3 + 1;

  logic       clock;
  logic       reset;
  arb_state_e dbg_state;
  int         cur;
  int         n_checks;
  int         n_errors;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  logic [3:0]  c_msg  [4];
  logic [31:0] c_addr [4];
  logic [31:0] c_data [4];
  logic [2:0]  c_ofs  [4];

  l1_bus_arbiter_if #(
    .NUM_CACHES(4), .MSG_BITS(4), .ADDRESS_BITS(32), .DATA_WIDTH(32),
    .BUS_OFFSET_BITS(0), .MAX_OFFSET_BITS(3)
  ) bus_if ();

  assign bus_if.cache_msg_in        = {c_msg[3], c_msg[2], c_msg[1], c_msg[0]};
  assign bus_if.cache_address_in    = {c_addr[3], c_addr[2], c_addr[1], c_addr[0]};
  assign bus_if.cache_data_in       = {c_data[3], c_data[2], c_data[1], c_data[0]};
  assign bus_if.cache_active_offset = {c_ofs[3], c_ofs[2], c_ofs[1], c_ofs[0]};

  l1_bus_arbiter #(
    .NUM_CACHES(4), .MSG_BITS(4), .ADDRESS_BITS(32), .DATA_WIDTH(32),
    .BUS_OFFSET_BITS(0), .MAX_OFFSET_BITS(3), .TIMEOUT(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus_if    (bus_if),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack_obs(logic [3:0] bm, logic rdy, logic [3:0] msg,
                                            logic [31:0] addr, logic [31:0] data,
                                            logic [2:0] ofs, logic err);
    return {bm, rdy, msg, addr, data, ofs, err};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
    cur++;
  endtask

  task automatic push_exp(input string name, input logic [3:0] bm, input logic rdy,
                          input logic [3:0] msg, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] ofs, input logic err);
    exp_q.push_back(pack_obs(bm, rdy, msg, addr, data, ofs, err));
    cyc_q.push_back(cur);
    name_q.push_back(name);
  endtask

  task automatic exp_idle(input string name, input logic err);
    push_exp(name, 4'b0000, 1'b0, NO_REQ, 32'h0, 32'h0, 3'd0, err);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    int           c;
    string        nm;
    forever begin
      @(negedge clock);
      while (cyc_q.size() > 0 && cyc_q[0] <= cur) begin
        got   = pack_obs(bus_if.bus_master, bus_if.req_ready, bus_if.bus_msg_out,
                         bus_if.bus_address_out, bus_if.bus_data_out,
                         bus_if.curr_offset, bus_if.timeout_err);
        exp_v = exp_q.pop_front();
        c     = cyc_q.pop_front();
        nm    = name_q.pop_front();
        n_checks++;
        if (c != cur) begin
          n_errors++;
          $display("FAIL %s: check for cycle %0d reached at cycle %0d", nm, c, cur);
        end else if (got !== exp_v) begin
          n_errors++;
          $display("FAIL %s: got bm=%b rdy=%b msg=%h addr=%h data=%h ofs=%0d err=%b, expected bm=%b rdy=%b msg=%h addr=%h data=%h ofs=%0d err=%b",
                   nm, got[76:73], got[72], got[71:68], got[67:36], got[35:4], got[3:1], got[0],
                   exp_v[76:73], exp_v[72], exp_v[71:68], exp_v[67:36], exp_v[35:4], exp_v[3:1], exp_v[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    cur      = 0;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    c_addr[0] = 32'h0000_0100; c_addr[1] = 32'h0000_0200;
    c_addr[2] = 32'h0000_1040; c_addr[3] = 32'h0000_0400;
    c_data[0] = 32'hDA7A_0000; c_data[1] = 32'hDA7A_0001;
    c_data[2] = 32'hDA7A_0002; c_data[3] = 32'hDA7A_0003;
    c_ofs[0] = 3'd1; c_ofs[1] = 3'd3; c_ofs[2] = 3'd2; c_ofs[3] = 3'd5;
    for (int i = 0; i < 4; i++) c_msg[i] = NO_REQ;
    bus_if.mem_msg_in     = NO_REQ;
    bus_if.mem_address_in = 32'h0;
    bus_if.mem_data_in    = 32'h0;

    // Reset and idle
    tick(); exp_idle("in_reset", 1'b0);
    tick(); reset = 1'b1; exp_idle("reset_release", 1'b0);
    tick(); exp_idle("idle", 1'b0);

    // Round robin 0,1,3,0 with one idle cycle between tenures
    tick(); c_msg[0] = R_REQ; c_msg[1] = R_REQ; c_msg[3] = R_REQ; exp_idle("rr_req", 1'b0);
    tick(); push_exp("rr_g0", 4'b0001, 1, R_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); c_msg[0] = NO_REQ; push_exp("rr_g0_rel", 4'b0001, 1, NO_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); c_msg[0] = R_REQ; exp_idle("rr_gap0", 1'b0);
    tick(); push_exp("rr_g1", 4'b0010, 1, R_REQ, 32'h200, 32'hDA7A_0001, 3'd3, 0);
    tick(); c_msg[1] = NO_REQ; push_exp("rr_g1_rel", 4'b0010, 1, NO_REQ, 32'h200, 32'hDA7A_0001, 3'd3, 0);
    tick(); c_msg[1] = R_REQ; exp_idle("rr_gap1", 1'b0);
    tick(); push_exp("rr_g3", 4'b1000, 1, R_REQ, 32'h400, 32'hDA7A_0003, 3'd5, 0);
    tick(); c_msg[3] = NO_REQ; push_exp("rr_g3_rel", 4'b1000, 1, NO_REQ, 32'h400, 32'hDA7A_0003, 3'd5, 0);
    tick(); c_msg[3] = R_REQ; exp_idle("rr_gap3", 1'b0);
    tick(); push_exp("rr_wrap_g0", 4'b0001, 1, R_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); for (int i = 0; i < 4; i++) c_msg[i] = NO_REQ;
            push_exp("rr_wrap_rel", 4'b0001, 1, NO_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); exp_idle("rr_done", 1'b0);

    // Cache 2 read, grant latency 1, memory response pre-empts the master
    tick(); c_msg[2] = R_REQ; exp_idle("t1_req", 1'b0);
    tick(); push_exp("t1_grant", 4'b0100, 1, R_REQ, 32'h0000_1040, 32'hDA7A_0002, 3'd2, 0);
    tick(); push_exp("t1_hold", 4'b0100, 1, R_REQ, 32'h0000_1040, 32'hDA7A_0002, 3'd2, 0);
    tick(); bus_if.mem_msg_in = MEM_RESP; bus_if.mem_address_in = 32'h2000; bus_if.mem_data_in = 32'hAAAA_5555;
            push_exp("t1_mem_resp", 4'b0100, 1, MEM_RESP, 32'h2000, 32'hAAAA_5555, 3'd2, 0);
    tick(); bus_if.mem_msg_in = NO_REQ; c_msg[2] = NO_REQ;
            push_exp("t1_release", 4'b0100, 1, NO_REQ, 32'h0000_1040, 32'hDA7A_0002, 3'd2, 0);
    tick(); exp_idle("t1_idle", 1'b0);

    // Cache 1 holds its request past the tenure limit
    tick(); c_msg[1] = R_REQ; exp_idle("to_req", 1'b0);
    tick(); push_exp("to_offset", 4'b0010, 1, R_REQ, 32'h200, 32'hDA7A_0001, 3'd3, 0);
    for (int k = 0; k < 14; k++) tick();
    tick(); push_exp("to_last", 4'b0010, 1, R_REQ, 32'h200, 32'hDA7A_0001, 3'd3, 0);
    tick(); c_msg[2] = R_REQ; exp_idle("to_err", 1'b1);
    tick(); push_exp("to_next_g2", 4'b0100, 1, R_REQ, 32'h0000_1040, 32'hDA7A_0002, 3'd2, 1);
    tick(); c_msg[1] = NO_REQ; c_msg[2] = NO_REQ;
            push_exp("to_next_rel", 4'b0100, 1, NO_REQ, 32'h0000_1040, 32'hDA7A_0002, 3'd2, 1);
    tick(); exp_idle("to_idle", 1'b1);

    // Write-back collides with a memory response
    tick(); c_msg[0] = WB_REQ; bus_if.mem_msg_in = MEM_RESP;
            bus_if.mem_address_in = 32'h5000; bus_if.mem_data_in = 32'h1111_2222;
            push_exp("wb_mem_wins", 4'b0000, 0, MEM_RESP, 32'h5000, 32'h1111_2222, 3'd0, 1);
    tick(); bus_if.mem_msg_in = NO_REQ;
            push_exp("wb_data", 4'b0001, 1, WB_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 1);
    tick(); c_msg[0] = NO_REQ; bus_if.mem_msg_in = C_RESP;
            bus_if.mem_address_in = 32'h6000; bus_if.mem_data_in = 32'h3333_4444;
            push_exp("rel_and_resp", 4'b0001, 1, C_RESP, 32'h6000, 32'h3333_4444, 3'd1, 1);
    tick(); bus_if.mem_msg_in = NO_REQ; exp_idle("wb_idle", 1'b1);

    // Asynchronous reset in the middle of a tenure
    tick(); c_msg[3] = R_REQ; exp_idle("ar_req", 1'b1);
    tick(); push_exp("ar_grant", 4'b1000, 1, R_REQ, 32'h400, 32'hDA7A_0003, 3'd5, 1);
    tick(); reset = 1'b0; bus_if.mem_msg_in = MEM_RESP; exp_idle("ar_async", 1'b0);
    tick(); reset = 1'b1; bus_if.mem_msg_in = NO_REQ; c_msg[0] = R_REQ; exp_idle("ar_after", 1'b0);
    tick(); push_exp("ar_rr_reset", 4'b0001, 1, R_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); for (int i = 0; i < 4; i++) c_msg[i] = NO_REQ;
            push_exp("ar_rel", 4'b0001, 1, NO_REQ, 32'h100, 32'hDA7A_0000, 3'd1, 0);
    tick(); exp_idle("ar_idle", 1'b0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
